// File: rtl/ha_pkg.sv
// ha_pkg -- shared definitions for the half-adder checker.
//   ha_state_e : checker FSM state encoding (IDLE, RUN, DONE)
//   HA_VEC_W   : width of a captured {a, b, Sum, Carry} vector
//   ha_pack_vec: packs one observed vector into HA_VEC_W bits
package ha_pkg;

  localparam int HA_VEC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ha_state_e;

  function automatic logic [HA_VEC_W-1:0] ha_pack_vec(
    input logic a,
    input logic b,
    input logic sum,
    input logic carry
  );
    return {a, b, sum, carry};
  endfunction

endpackage

// File: rtl/ha_ref_model.sv
// ha_ref_model -- combinational golden half adder.
//   a, b      : stimulus bits
//   Sum_exp   : expected sum   (a ^ b)
//   Carry_exp : expected carry (a & b)
module ha_ref_model (
  input  logic a,
  input  logic b,
  output logic Sum_exp,
  output logic Carry_exp
);

  assign Sum_exp   = a ^ b;
  assign Carry_exp = a & b;

endmodule

// File: rtl/ha_checker.sv
// ha_checker -- checks a half adder's responses against a golden model over
// a run of N_VECTORS vectors, with an idle timer that aborts a stalled run.
//   clk, rst_n         : clock, async active-low reset
//   start              : pulse, begins a run from IDLE or DONE
//   in_valid, a, b,
//   Sum, Carry         : one observed vector per valid cycle
//   busy, done, pass   : run status; pass only meaningful while done
//   timeout            : run ended by the idle timer
//   err_pulse          : high the cycle after a mismatching vector
//   vec_cnt, err_cnt   : accepted / mismatching vectors this run
//   first_fail_idx/vec : index and contents of the first mismatch
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting vectors, idle timer active
// DONE  | run finished (all vectors or timeout), results held
module ha_checker
  import ha_pkg::*;
#(
  parameter int N_VECTORS = 4,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic                a,
  input  logic                b,
  input  logic                Sum,
  input  logic                Carry,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic                err_pulse,
  output logic [CNT_W-1:0]    vec_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    first_fail_idx,
  output logic [HA_VEC_W-1:0] first_fail_vec
);

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_VEC_C   = CNT_W'(N_VECTORS);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX_C = '1;

  logic sum_exp;
  logic carry_exp;
  logic mismatch;

  ha_state_e           state_q, state_d;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    idle_tmr_q, idle_tmr_d;
  logic [CNT_W-1:0]    first_fail_idx_q, first_fail_idx_d;
  logic [HA_VEC_W-1:0] first_fail_vec_q, first_fail_vec_d;
  logic                timeout_q, timeout_d;
  logic                err_pulse_q, err_pulse_d;

  ha_ref_model u_ref (
    .a         (a),
    .b         (b),
    .Sum_exp   (sum_exp),
    .Carry_exp (carry_exp)
  );

  assign mismatch = (Sum != sum_exp) || (Carry != carry_exp);

  always_comb begin
    state_d          = state_q;
    vec_cnt_d        = vec_cnt_q;
    err_cnt_d        = err_cnt_q;
    idle_tmr_d       = idle_tmr_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_vec_d = first_fail_vec_q;
    timeout_d        = timeout_q;
    err_pulse_d      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_cnt_d        = '0;
          err_cnt_d        = '0;
          idle_tmr_d       = '0;
          first_fail_idx_d = '0;
          first_fail_vec_d = '0;
          timeout_d        = 1'b0;
          state_d          = RUN;
        end
      end

      RUN: begin
        if (in_valid) begin
          vec_cnt_d  = vec_cnt_q + ONE_C;
          idle_tmr_d = '0;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != CNT_MAX_C) begin
              err_cnt_d = err_cnt_q + ONE_C;
            end
            // err_cnt saturates and never wraps, so zero means "no fail yet"
            if (err_cnt_q == '0) begin
              first_fail_idx_d = vec_cnt_q;
              first_fail_vec_d = ha_pack_vec(a, b, Sum, Carry);
            end
          end
          // Acceptance takes priority over the timer: the timer is not
          // advanced on an accepting cycle, so the last vector can never
          // be reported as a timeout.
          if (vec_cnt_d == N_VEC_C) begin
            state_d = DONE;
          end
        end else begin
          idle_tmr_d = idle_tmr_q + ONE_C;
          if (idle_tmr_d == TIMEOUT_C) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      vec_cnt_q        <= '0;
      err_cnt_q        <= '0;
      idle_tmr_q       <= '0;
      first_fail_idx_q <= '0;
      first_fail_vec_q <= '0;
      timeout_q        <= 1'b0;
      err_pulse_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_cnt_q        <= vec_cnt_d;
      err_cnt_q        <= err_cnt_d;
      idle_tmr_q       <= idle_tmr_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_vec_q <= first_fail_vec_d;
      timeout_q        <= timeout_d;
      err_pulse_q      <= err_pulse_d;
    end
  end

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = done && (err_cnt_q == '0) && !timeout_q;
  assign timeout        = timeout_q;
  assign err_pulse      = err_pulse_q;
  assign vec_cnt        = vec_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_vec = first_fail_vec_q;

endmodule

// File: tb/tb_ha_checker.sv
// tb_ha_checker -- directed bench for ha_checker with a behavioural run
// model compared against the DUT every cycle, plus literal expectations.
module tb_ha_checker;

  localparam int N_VEC = 4;
  localparam int CW    = 8;
  localparam int TMO   = 64;

  logic clk, rst_n, start, in_valid, a, b, Sum, Carry;
  logic busy, done, pass, timeout, err_pulse;
  logic [CW-1:0] vec_cnt, err_cnt, first_fail_idx;
  logic [3:0]    first_fail_vec;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_hi = 0;

  ha_checker #(.N_VECTORS(N_VEC), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .a              (a),
    .b              (b),
    .Sum            (Sum),
    .Carry          (Carry),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_pulse      (err_pulse),
    .vec_cnt        (vec_cnt),
    .err_cnt        (err_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a run is "running" or "finished"; results are plain ints.
  bit m_running  = 0;
  bit m_finished = 0;
  bit m_timeout  = 0;
  bit m_pulse    = 0;
  int m_vecs     = 0;
  int m_errs     = 0;
  int m_idle     = 0;
  int m_first_idx = 0;
  int m_first_vec = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 0; m_finished = 0; m_timeout = 0; m_pulse = 0;
      m_vecs = 0; m_errs = 0; m_idle = 0; m_first_idx = 0; m_first_vec = 0;
    end else begin
      m_pulse = 0;
      if (!m_running) begin
        if (start) begin
          m_running = 1; m_finished = 0; m_timeout = 0;
          m_vecs = 0; m_errs = 0; m_idle = 0; m_first_idx = 0; m_first_vec = 0;
        end
      end else if (in_valid) begin
        // a half adder is correct when its 2-bit result equals a+b
        if ((int'(a) + int'(b)) != (2 * int'(Carry) + int'(Sum))) begin
          if (m_errs == 0) begin
            m_first_idx = m_vecs;
            m_first_vec = 8 * int'(a) + 4 * int'(b) + 2 * int'(Sum) + int'(Carry);
          end
          if (m_errs < (1 << CW) - 1) m_errs++;
          m_pulse = 1;
        end
        m_vecs++;
        m_idle = 0;
        if (m_vecs == N_VEC) begin m_running = 0; m_finished = 1; end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_running = 0; m_finished = 1; m_timeout = 1; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy",      busy,      m_running);
    chk("done",      done,      m_finished);
    chk("pass",      pass,      m_finished && m_errs == 0 && !m_timeout);
    chk("timeout",   timeout,   m_timeout);
    chk("err_pulse", err_pulse, m_pulse);
    chk("vec_cnt",   vec_cnt,   m_vecs);
    chk("err_cnt",   err_cnt,   m_errs);
    chk("ff_idx",    first_fail_idx, m_first_idx);
    chk("ff_vec",    first_fail_vec, m_first_vec);
    if (err_pulse === 1'b1) pulse_hi++;
  end

  // all stimulus tasks are entered just after a falling edge
  task automatic apply_vec(input logic [3:0] v);
    in_valid = 1'b1;
    {a, b, Sum, Carry} = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    {a, b, Sum, Carry} = 4'b0000;
    idle(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    rst_n = 1'b1;
    idle(1);

    // in_valid while IDLE is ignored
    apply_vec(4'b0000);
    apply_vec(4'b1000);
    chk("idle_vec_cnt", vec_cnt, 0);
    chk("idle_err_cnt", err_cnt, 0);

    // all-correct run
    pulse_start();
    chk("s1_busy", busy, 1);
    pulse_hi = 0;
    apply_vec(4'b0000);
    apply_vec(4'b0110);
    apply_vec(4'b1010);
    chk("s1_done_early", done, 0);
    apply_vec(4'b1101);
    chk("s1_done", done, 1);
    chk("s1_vec_cnt", vec_cnt, 4);
    chk("s1_err_cnt", err_cnt, 0);
    chk("s1_pass", pass, 1);
    chk("s1_pulses", pulse_hi, 0);
    chk("s1_model_vecs", m_vecs, 4);
    idle(3);
    chk("s1_hold_done", done, 1);
    chk("s1_hold_vec", vec_cnt, 4);

    // vector 3 wrong: restart from DONE
    pulse_start();
    pulse_hi = 0;
    apply_vec(4'b0000);
    apply_vec(4'b0110);
    apply_vec(4'b1000);
    apply_vec(4'b1101);
    chk("s2_err_cnt", err_cnt, 1);
    chk("s2_ff_idx", first_fail_idx, 2);
    chk("s2_ff_vec", first_fail_vec, 4'b1000);
    chk("s2_pass", pass, 0);
    chk("s2_done", done, 1);
    chk("s2_pulses", pulse_hi, 1);
    chk("s2_model_errs", m_errs, 1);

    // vectors 1 and 3 wrong
    pulse_start();
    pulse_hi = 0;
    apply_vec(4'b0010);
    apply_vec(4'b0110);
    apply_vec(4'b1000);
    apply_vec(4'b1101);
    chk("s3_err_cnt", err_cnt, 2);
    chk("s3_ff_idx", first_fail_idx, 0);
    chk("s3_ff_vec", first_fail_vec, 4'b0010);
    chk("s3_pulses", pulse_hi, 2);

    // stall after two vectors: 63 idle cycles survive, the 64th aborts
    pulse_start();
    apply_vec(4'b0000);
    apply_vec(4'b1101);
    idle(TMO - 1);
    chk("s4_busy_pre", busy, 1);
    chk("s4_tmo_pre", timeout, 0);
    idle(1);
    chk("s4_timeout", timeout, 1);
    chk("s4_done", done, 1);
    chk("s4_pass", pass, 0);
    chk("s4_vec_cnt", vec_cnt, 2);

    // last vector lands on the expiry cycle: acceptance wins
    pulse_start();
    apply_vec(4'b0000);
    apply_vec(4'b0110);
    apply_vec(4'b1010);
    idle(TMO - 1);
    apply_vec(4'b1101);
    chk("s5_timeout", timeout, 0);
    chk("s5_done", done, 1);
    chk("s5_pass", pass, 1);
    chk("s5_vec_cnt", vec_cnt, 4);

    // start while busy is ignored, with and without a vector
    pulse_start();
    apply_vec(4'b0000);
    apply_vec(4'b0110);
    start = 1'b1;
    apply_vec(4'b1010);
    start = 1'b0;
    pulse_start();
    chk("s6_vec_mid", vec_cnt, 3);
    chk("s6_busy_mid", busy, 1);
    apply_vec(4'b1101);
    chk("s6_vec_cnt", vec_cnt, 4);
    chk("s6_pass", pass, 1);

    // reset mid-run, then a clean run
    pulse_start();
    apply_vec(4'b0010);
    apply_vec(4'b0110);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_vec", vec_cnt, 0);
    chk("rst_mid_err", err_cnt, 0);
    chk("rst_mid_ffidx", first_fail_idx, 0);
    chk("rst_mid_ffvec", first_fail_vec, 0);
    chk("rst_mid_pulse", err_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(4'b0110);
    chk("rel_vec_cnt", vec_cnt, 0);
    pulse_start();
    apply_vec(4'b0000);
    apply_vec(4'b0110);
    apply_vec(4'b1010);
    apply_vec(4'b1101);
    chk("s7_pass", pass, 1);
    chk("s7_vec_cnt", vec_cnt, 4);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
